// File: rtl/pipe_shifter_if.sv
// Handshake and operand bundle for the pipelined barrel shifter.
// master drives operations and consumes results; slave is the shifter.
interface pipe_shifter_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sh;
    logic             reg_amt;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] operand;
    logic             carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;

    modport master (
        output in_valid, sh, reg_amt, amt, operand, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    modport slave (
        input  in_valid, sh, reg_amt, amt, operand, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out
    );
endinterface

// File: rtl/pipe_shifter.sv
// ARM-style barrel shifter for the execute stage.
// Shift is resolved ahead of stage 0; the pipe stalls globally on back-pressure.
module pipe_shifter #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int AMT_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    output logic          busy,
    pipe_shifter_if.slave io
);
    localparam int LW = $clog2(WIDTH);
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } sh_e;

    typedef struct packed {
        logic             v;
        logic             c;
        logic [WIDTH-1:0] r;
    } stg_t;

    stg_t             pipe_q [STAGES];
    stg_t             head;
    logic             advance;

    sh_e              op_sh;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] sgn;
    logic [WIDTH-1:0] lsl_r;
    logic [WIDTH-1:0] lsr_r;
    logic [WIDTH-1:0] asr_r;
    logic [WIDTH-1:0] ror_r;
    logic [LW-1:0]    k;
    logic [LW-1:0]    nk;
    logic [AMT_W-1:0] n;
    logic             msb;
    logic             imm0;
    logic             reg0;
    logic             mid;
    logic             at_w;
    logic             over;

    always_comb begin
        op_sh = sh_e'(io.sh);
        op    = io.operand;
        msb   = op[WIDTH-1];
        sgn   = {WIDTH{msb}};
        n     = io.amt;
        k     = io.amt[LW-1:0];
        nk    = (~k) + LW'(1);
        lsl_r = op << k;
        lsr_r = op >> k;
        asr_r = $unsigned($signed(op) >>> k);
        // with k == 0 both halves are op, so this also covers rotate-by-W
        ror_r = (op >> k) | (op << nk);
        imm0  = !io.reg_amt && (k == '0);
        reg0  = io.reg_amt && (n == '0);
        mid   = io.reg_amt ? (n != '0 && n < W_AMT) : (k != '0);
        at_w  = io.reg_amt && (n == W_AMT);
        over  = io.reg_amt && (n > W_AMT);
    end

    always_comb begin
        head.v = io.in_valid;
        head.r = op;
        head.c = io.carry_in;
        unique case (1'b1)
            reg0: begin
                head.r = op;
                head.c = io.carry_in;
            end
            imm0: begin
                unique case (op_sh)
                    SH_LSL: begin
                        head.r = op;
                        head.c = io.carry_in;
                    end
                    SH_LSR: begin
                        head.r = '0;
                        head.c = msb;
                    end
                    SH_ASR: begin
                        head.r = sgn;
                        head.c = msb;
                    end
                    SH_ROR: begin
                        head.r = {io.carry_in, op[WIDTH-1:1]};
                        head.c = op[0];
                    end
                endcase
            end
            mid: begin
                unique case (op_sh)
                    SH_LSL: begin
                        head.r = lsl_r;
                        head.c = op[nk];
                    end
                    SH_LSR: begin
                        head.r = lsr_r;
                        head.c = op[k - LW'(1)];
                    end
                    SH_ASR: begin
                        head.r = asr_r;
                        head.c = op[k - LW'(1)];
                    end
                    SH_ROR: begin
                        head.r = ror_r;
                        head.c = ror_r[WIDTH-1];
                    end
                endcase
            end
            at_w: begin
                unique case (op_sh)
                    SH_LSL: begin
                        head.r = '0;
                        head.c = op[0];
                    end
                    SH_LSR: begin
                        head.r = '0;
                        head.c = msb;
                    end
                    SH_ASR: begin
                        head.r = sgn;
                        head.c = msb;
                    end
                    SH_ROR: begin
                        head.r = op;
                        head.c = msb;
                    end
                endcase
            end
            over: begin
                unique case (op_sh)
                    SH_LSL, SH_LSR: begin
                        head.r = '0;
                        head.c = 1'b0;
                    end
                    SH_ASR: begin
                        head.r = sgn;
                        head.c = msb;
                    end
                    SH_ROR: begin
                        head.r = ror_r;
                        head.c = ror_r[WIDTH-1];
                    end
                endcase
            end
            default: begin
                head.r = op;
                head.c = io.carry_in;
            end
        endcase
    end

    assign advance = !pipe_q[STAGES-1].v || io.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i].v <= 1'b0;
        end else if (advance) begin
            pipe_q[0] <= head;
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) busy = busy | pipe_q[i].v;
    end

    assign io.in_ready  = advance;
    assign io.out_valid = pipe_q[STAGES-1].v;
    assign io.result    = pipe_q[STAGES-1].r;
    assign io.carry_out = pipe_q[STAGES-1].c;
endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed corner cases plus random traffic
// scored against a bit-serial ARM shift model.
module tb_pipe_shifter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic busy;

    int checks = 0;
    int errors = 0;
    int n_out = 0;

    logic [32:0] sb [$];
    logic [32:0] mon_e;

    pipe_shifter_if #(.WIDTH(32), .AMT_W(8)) io ();

    pipe_shifter #(.WIDTH(32), .STAGES(2), .AMT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .io    (io)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shifts one bit at a time; carry is simply the last bit shifted out.
    function automatic logic [32:0] model(logic [1:0] s, logic ra,
                                          logic [7:0] a, logic [31:0] x,
                                          logic ci);
        int          cnt;
        logic [31:0] v;
        logic        c;
        v = x;
        c = ci;
        cnt = ra ? int'(a) : int'(a[4:0]);
        if (!ra && cnt == 0) begin
            if (s == 2'b11) return {x[0], ci, x[31:1]};
            if (s != 2'b00) cnt = 32;
        end
        for (int i = 0; i < cnt; i++) begin
            case (s)
                2'b00: begin c = v[31]; v = {v[30:0], 1'b0}; end
                2'b01: begin c = v[0];  v = {1'b0, v[31:1]}; end
                2'b10: begin c = v[0];  v = {v[31], v[31:1]}; end
                default: begin c = v[0]; v = {v[0], v[31:1]}; end
            endcase
        end
        return {c, v};
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (io.out_valid && io.out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("spurious_out", io.out_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sb_res", io.result, mon_e[31:0]);
                    chk("sb_carry", io.carry_out, mon_e[32]);
                end
            end
            if (flush) sb.delete();
            else if (io.in_valid && io.in_ready)
                sb.push_back(model(io.sh, io.reg_amt, io.amt,
                                   io.operand, io.carry_in));
        end
    end

    task automatic drive(logic [1:0] s, logic ra, logic [7:0] a,
                         logic [31:0] x, logic ci);
        io.sh       = s;
        io.reg_amt  = ra;
        io.amt      = a;
        io.operand  = x;
        io.carry_in = ci;
    endtask

    task automatic rand_op();
        logic [7:0] a;
        case ($urandom_range(0, 5))
            0: a = 8'd0;
            1: a = 8'd32;
            2: a = 8'd33;
            3: a = 8'($urandom_range(1, 31));
            4: a = 8'($urandom_range(34, 255));
            default: a = 8'd31;
        endcase
        drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a,
              $urandom, 1'($urandom_range(0, 1)));
    endtask

    // Issues one op into an empty pipe and checks the 2-cycle latency.
    task automatic single(string tag, logic [1:0] s, logic ra,
                          logic [7:0] a, logic [31:0] x, logic ci,
                          logic [31:0] er, logic ec);
        drive(s, ra, a, x, ci);
        io.in_valid  = 1'b1;
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        chk({tag, "_lat"}, io.out_valid, 0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, io.out_valid, 1);
        chk({tag, "_res"}, io.result, er);
        chk({tag, "_c"}, io.carry_out, ec);
        @(posedge clk); #1;
    endtask

    initial begin
        int  sent;
        int  hold;
        int  base;
        bit  seen;
        bit  acc;

        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        drive(2'b00, 1'b0, 8'd0, 32'd0, 1'b0);

        #12;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_result", io.result, 0);
        chk("rst_carry", io.carry_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", io.in_ready, 1);
        reset = 1'b1;
        @(posedge clk); #1;

        single("lsl4", 2'b00, 1'b1, 8'd4, 32'h8000000F, 1'b0, 32'h000000F0, 1'b0);
        single("lsl33", 2'b00, 1'b1, 8'd33, 32'h8000000F, 1'b0, 32'h0, 1'b0);
        single("lsr0", 2'b01, 1'b0, 8'd0, 32'h80000001, 1'b0, 32'h0, 1'b1);
        single("asr0", 2'b10, 1'b0, 8'd0, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1);
        single("rrx", 2'b11, 1'b0, 8'd0, 32'h00000003, 1'b1, 32'h80000001, 1'b1);
        single("ror32", 2'b11, 1'b1, 8'h20, 32'h80000000, 1'b0, 32'h80000000, 1'b1);
        single("lsl32", 2'b00, 1'b1, 8'd32, 32'h00000001, 1'b0, 32'h0, 1'b1);
        single("asr40", 2'b10, 1'b1, 8'd40, 32'h40000000, 1'b1, 32'h0, 1'b0);

        // back-pressure: 4 back-to-back ops, 3-cycle hold on first result
        base = n_out;
        sent = 0;
        hold = 0;
        seen = 1'b0;
        io.out_ready = 1'b1;
        rand_op();
        io.in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && (sent < 4 || sb.size() > 0); cyc++) begin
            @(negedge clk);
            if (hold > 0) begin
                chk("bp_in_ready", io.in_ready, 0);
                if (sb.size() > 0) chk("bp_stable", io.result, sb[0][31:0]);
            end
            acc = io.in_valid && io.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4) rand_op();
                else io.in_valid = 1'b0;
            end
            if (hold > 0) begin
                hold--;
                if (hold == 0) io.out_ready = 1'b1;
            end
            if (io.out_valid && !seen) begin
                seen = 1'b1;
                hold = 3;
                io.out_ready = 1'b0;
            end
        end
        chk("bp_count", n_out - base, 4);
        chk("bp_drained", sb.size(), 0);
        chk("bp_busy", busy, 0);

        // flush with two ops in flight and a third presented
        base = n_out;
        io.out_ready = 1'b0;
        rand_op();
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        rand_op();
        @(posedge clk); #1;
        chk("fl_pre_valid", io.out_valid, 1);
        rand_op();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        io.in_valid = 1'b0;
        chk("fl_valid", io.out_valid, 0);
        chk("fl_busy", busy, 0);
        io.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("fl_none_out", n_out - base, 0);
        chk("fl_valid_late", io.out_valid, 0);

        // asynchronous reset while a result is stalled at the output
        io.out_ready = 1'b0;
        rand_op();
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_pre_valid", io.out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", io.out_valid, 0);
        chk("ar_result", io.result, 0);
        chk("ar_carry", io.carry_out, 0);
        chk("ar_busy", busy, 0);
        chk("ar_in_ready", io.in_ready, 1);
        sb.delete();
        #3;
        reset = 1'b1;
        io.out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("ar_quiet", io.out_valid, 0);
        end
        chk("ar_no_out", n_out - base, 0);
        single("post_rst", 2'b01, 1'b1, 8'd1, 32'h00000003, 1'b0, 32'h00000001, 1'b1);

        // random traffic with stalls and occasional flushes
        for (int i = 0; i < 400; i++) begin
            rand_op();
            io.in_valid  = ($urandom_range(0, 9) < 7);
            io.out_ready = ($urandom_range(0, 9) < 7);
            flush        = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("rnd_drained", sb.size(), 0);
        chk("rnd_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
